// File: rtl/joystick_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_pkg                                           |
// | Description : Shared types and constants for the joystick ADC        |
// |               sequencer: direction codes, FSM state codes and the    |
// |               12-bit ADC mid-scale value.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package joystick_pkg;

  // Decoded joystick direction
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  // Sequencer FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD_X  = 3'd1;
  localparam state_t ST_WAIT_X = 3'd2;
  localparam state_t ST_CMD_Y  = 3'd3;
  localparam state_t ST_WAIT_Y = 3'd4;
  localparam state_t ST_UPDATE = 3'd5;

  // Centre code of a 12-bit ADC
  localparam logic [11:0] ADC_MID = 12'd2048;

endpackage
`default_nettype wire

// File: rtl/joystick_dir_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_dir_decode                                    |
// | Description : Combinational direction decode of one X/Y sample pair. |
// |               The deflected axis with the larger deviation from the  |
// |               centre wins; X wins ties.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module joystick_dir_decode
  import joystick_pkg::*;
#(
  parameter int LOW_TH  = 1024,
  parameter int HIGH_TH = 3072
) (
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  output logic        deflected_o,
  output dir_t        dir_o
);

  logic [12:0] dx, dy, adx, ady;
  logic        x_lo, x_hi, y_lo, y_hi;
  logic        x_defl, y_defl, x_wins;

  // 13-bit two's-complement deviations from centre and their magnitudes
  always_comb begin
    dx  = {1'b0, x_i} - {1'b0, ADC_MID};
    dy  = {1'b0, y_i} - {1'b0, ADC_MID};
    adx = dx[12] ? (~dx + 13'd1) : dx;
    ady = dy[12] ? (~dy + 13'd1) : dy;
  end

  // Threshold tests, winner selection and direction code
  always_comb begin
    x_lo        = x_i < 12'(LOW_TH);
    x_hi        = x_i > 12'(HIGH_TH);
    y_lo        = y_i < 12'(LOW_TH);
    y_hi        = y_i > 12'(HIGH_TH);
    x_defl      = x_lo | x_hi;
    y_defl      = y_lo | y_hi;
    deflected_o = x_defl | y_defl;
    // A non-deflected axis can never beat a deflected one on magnitude
    // with centred thresholds, but the explicit gating keeps the rule
    // correct for asymmetric threshold settings too.
    x_wins      = x_defl & (~y_defl | (adx >= ady));
    if (x_wins) begin
      dir_o = x_lo ? DIR_LEFT : DIR_RIGHT;
    end else begin
      dir_o = y_hi ? DIR_UP : DIR_DOWN;
    end
  end

endmodule
`default_nettype wire

// File: rtl/joystick_adc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_adc_sequencer                                 |
// | Description : Periodically requests X then Y conversions from an     |
// |               ADC command/response stream, publishes the pair and a  |
// |               decoded joystick direction.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module joystick_adc_sequencer
  import joystick_pkg::*;
#(
  parameter int CH_X       = 1,
  parameter int CH_Y       = 2,
  parameter int SAMPLE_DIV = 50000,
  parameter int TIMEOUT    = 1023,
  parameter int LOW_TH     = 1024,
  parameter int HIGH_TH    = 3072
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset_n,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic [11:0] x_data,
  output logic [11:0] y_data,
  output logic        sample_valid,
  output logic [1:0]  direction,
  output logic        dir_valid,
  output logic        timeout_err,
  output logic        tick_missed
);

  localparam int            PW       = $clog2(SAMPLE_DIV);
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [4:0]    CHX5     = 5'(CH_X);
  localparam logic [4:0]    CHY5     = 5'(CH_Y);

  state_t        state_q, state_d;
  logic [PW-1:0] period_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [11:0]   xcap_q, xcap_d, ycap_q, ycap_d;
  logic [11:0]   x_data_q, y_data_q;
  dir_t          dir_q;
  logic          dir_valid_q, sample_valid_q, timeout_err_q, tick_missed_q;
  logic          tick, match_x, match_y, timeout_hit;
  logic          dec_deflected;
  dir_t          dec_dir;

  // Packet framing flags of the response stream carry no information here
  logic unused_resp_flags;
  assign unused_resp_flags = &{1'b0, response_startofpacket, response_endofpacket};

  assign tick    = (period_q == PER_LAST);
  assign match_x = response_valid && (response_channel == CHX5);
  assign match_y = response_valid && (response_channel == CHY5);

  joystick_dir_decode #(
    .LOW_TH  (LOW_TH),
    .HIGH_TH (HIGH_TH)
  ) u_dir_decode (
    .x_i         (xcap_q),
    .y_i         (ycap_q),
    .deflected_o (dec_deflected),
    .dir_o       (dec_dir)
  );

  // Free-running sample period counter; tick is its wrap cycle
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      period_q <= '0;
    end else if (tick) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + PW'(1);
    end
  end

  // Sequencer next-state, response capture and timeout counting
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    xcap_d      = xcap_q;
    ycap_d      = ycap_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_CMD_X;
      end
      ST_CMD_X: begin
        if (command_ready) begin
          state_d = ST_WAIT_X;
          tcnt_d  = '0;
        end
      end
      ST_WAIT_X: begin
        if (match_x) begin
          xcap_d  = response_data;
          state_d = ST_CMD_Y;
        end else if (tcnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_CMD_Y: begin
        if (command_ready) begin
          state_d = ST_WAIT_Y;
          tcnt_d  = '0;
        end
      end
      ST_WAIT_Y: begin
        if (match_y) begin
          ycap_d  = response_data;
          state_d = ST_UPDATE;
        end else if (tcnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, capture and output registers; outputs change only on UPDATE
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q        <= ST_IDLE;
      tcnt_q         <= '0;
      xcap_q         <= ADC_MID;
      ycap_q         <= ADC_MID;
      x_data_q       <= ADC_MID;
      y_data_q       <= ADC_MID;
      dir_q          <= DIR_UP;
      dir_valid_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      tick_missed_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tcnt_q         <= tcnt_d;
      xcap_q         <= xcap_d;
      ycap_q         <= ycap_d;
      sample_valid_q <= (state_q == ST_UPDATE);
      timeout_err_q  <= timeout_hit;
      if (tick && (state_q != ST_IDLE)) begin
        tick_missed_q <= 1'b1;
      end
      if (state_q == ST_UPDATE) begin
        x_data_q    <= xcap_q;
        y_data_q    <= ycap_q;
        dir_valid_q <= dec_deflected;
        if (dec_deflected) begin
          dir_q <= dec_dir;
        end
      end
    end
  end

  assign command_valid         = (state_q == ST_CMD_X) || (state_q == ST_CMD_Y);
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign command_channel       = (state_q == ST_CMD_X) ? CHX5 :
                                 (state_q == ST_CMD_Y) ? CHY5 : 5'd0;
  assign x_data                = x_data_q;
  assign y_data                = y_data_q;
  assign sample_valid          = sample_valid_q;
  assign direction             = dir_q;
  assign dir_valid             = dir_valid_q;
  assign timeout_err           = timeout_err_q;
  assign tick_missed           = tick_missed_q;

endmodule
`default_nettype wire

// File: tb/tb_joystick_adc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_joystick_adc_sequencer                              |
// | Description : Self-checking bench: ADC responder, transaction-level  |
// |               reference model and per-cycle output comparison.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_joystick_adc_sequencer;

  localparam int CH_X       = 1;
  localparam int CH_Y       = 2;
  localparam int SAMPLE_DIV = 40;
  localparam int TIMEOUT    = 15;
  localparam int LOW_TH     = 1024;
  localparam int HIGH_TH    = 3072;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel;
  logic        command_ready = 1'b0;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = 5'd0;
  logic [11:0] response_data = 12'd0;
  logic        response_sop = 1'b0, response_eop = 1'b0;
  logic [11:0] x_data, y_data;
  logic        sample_valid, dir_valid, timeout_err, tick_missed;
  logic [1:0]  direction;

  always #5 clk = ~clk;

  joystick_adc_sequencer #(
    .CH_X(CH_X), .CH_Y(CH_Y), .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT),
    .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH)
  ) dut (
    .clock_clk              (clk),
    .reset_sink_reset_n     (rst_n),
    .command_valid          (command_valid),
    .command_channel        (command_channel),
    .command_startofpacket  (command_startofpacket),
    .command_endofpacket    (command_endofpacket),
    .command_ready          (command_ready),
    .response_valid         (response_valid),
    .response_channel       (response_channel),
    .response_data          (response_data),
    .response_startofpacket (response_sop),
    .response_endofpacket   (response_eop),
    .x_data                 (x_data),
    .y_data                 (y_data),
    .sample_valid           (sample_valid),
    .direction              (direction),
    .dir_valid              (dir_valid),
    .timeout_err            (timeout_err),
    .tick_missed            (tick_missed)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_per = 0;
  bit          m_busy = 0, m_cmd = 0, m_upd = 0;
  int          m_axis = 0, m_waited = 0, m_capx = 0, m_capy = 0;
  logic [11:0] e_x = 12'd2048, e_y = 12'd2048;
  logic [1:0]  e_dir = 2'd0;
  bit          e_dv = 0, e_sv = 0, e_to = 0, e_tm = 0;

  task automatic model_publish();
    int  dx, dy, adx, ady;
    bit  dfx, dfy, xw;
    dx  = m_capx - 2048;
    dy  = m_capy - 2048;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    dfx = (m_capx < LOW_TH) || (m_capx > HIGH_TH);
    dfy = (m_capy < LOW_TH) || (m_capy > HIGH_TH);
    e_x  = 12'(m_capx);
    e_y  = 12'(m_capy);
    e_sv = 1;
    if (!dfx && !dfy) begin
      e_dv = 0;
    end else begin
      e_dv = 1;
      xw = (adx >= ady);
      if (xw && !dfx) xw = 0;
      if (!xw && !dfy) xw = 1;
      if (xw) e_dir = (m_capx < LOW_TH) ? 2'd2 : 2'd3;
      else    e_dir = (m_capy > HIGH_TH) ? 2'd0 : 2'd1;
    end
  endtask

  task automatic model_step();
    bit tick;
    int want;
    if (!rst_n) begin
      m_per = 0; m_busy = 0; m_cmd = 0; m_upd = 0; m_axis = 0; m_waited = 0;
      e_x = 12'd2048; e_y = 12'd2048; e_dir = 2'd0;
      e_dv = 0; e_sv = 0; e_to = 0; e_tm = 0;
      return;
    end
    tick  = (m_per == SAMPLE_DIV - 1);
    m_per = tick ? 0 : m_per + 1;
    e_sv  = 0;
    e_to  = 0;
    want  = (m_axis != 0) ? CH_Y : CH_X;
    if (!m_busy) begin
      if (tick) begin m_busy = 1; m_cmd = 1; m_axis = 0; end
    end else begin
      if (tick) e_tm = 1;
      if (m_upd) begin
        model_publish();
        m_busy = 0; m_upd = 0;
      end else if (m_cmd) begin
        if (command_ready) begin m_cmd = 0; m_waited = 0; end
      end else if (response_valid && (int'(response_channel) == want)) begin
        if (m_axis == 0) begin m_capx = int'(response_data); m_axis = 1; m_cmd = 1; end
        else begin m_capy = int'(response_data); m_upd = 1; end
      end else if (m_waited + 1 >= TIMEOUT) begin
        e_to = 1; m_busy = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    bit e_cv;
    @(posedge clk);
    #2;
    e_cv = m_busy && m_cmd;
    chk("cmd_valid", 32'(command_valid), 32'(e_cv));
    chk("cmd_sop", 32'(command_startofpacket), 32'(e_cv));
    chk("cmd_eop", 32'(command_endofpacket), 32'(e_cv));
    chk("cmd_channel", 32'(command_channel), e_cv ? ((m_axis != 0) ? CH_Y : CH_X) : 0);
    chk("x_data", 32'(x_data), 32'(e_x));
    chk("y_data", 32'(y_data), 32'(e_y));
    chk("direction", 32'(direction), 32'(e_dir));
    chk("dir_valid", 32'(dir_valid), 32'(e_dv));
    chk("sample_valid", 32'(sample_valid), 32'(e_sv));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    chk("tick_missed", 32'(tick_missed), 32'(e_tm));
  end

  // ---------------- ADC responder / stimulus driver ----------------
  int          cyc = 0;
  int          rdy_mode = 0;      // 0 always ready, 1 random, 2 never
  int          noise_mode = 0;    // 0 off, 1 random channel, 2 channel 7 every idle cycle
  int          dly_min = 5, dly_max = 5;
  int          fixed_x = -1, fixed_y = -1;
  bit          drop_y = 0;
  bit          pend = 0;
  int          pend_due = 0;
  logic [4:0]  pend_ch = 5'd0;
  logic [11:0] pend_dat = 12'd0;

  function automatic logic [11:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 12'($urandom_range(0, 1023));
      1:       return 12'($urandom_range(3073, 4095));
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic step();
    int d;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       command_ready = 1'b1;
      1:       command_ready = ($urandom_range(0, 2) != 0);
      default: command_ready = 1'b0;
    endcase
    if (command_valid && command_ready) begin
      d = $urandom_range(dly_min, dly_max);
      if (!(drop_y && command_channel == 5'(CH_Y))) begin
        pend     = 1;
        pend_due = cyc + d;
        pend_ch  = command_channel;
        if (command_channel == 5'(CH_X)) pend_dat = (fixed_x >= 0) ? 12'(fixed_x) : rnd_data();
        else                             pend_dat = (fixed_y >= 0) ? 12'(fixed_y) : rnd_data();
      end
    end
    response_sop = 1'($urandom_range(0, 1));
    response_eop = 1'($urandom_range(0, 1));
    if (pend && cyc >= pend_due) begin
      response_valid   = 1'b1;
      response_channel = pend_ch;
      response_data    = pend_dat;
      pend = 0;
    end else if (noise_mode == 2) begin
      response_valid   = 1'b1;
      response_channel = 5'd7;
      response_data    = rnd_data();
    end else if (noise_mode == 1 && $urandom_range(0, 3) == 0) begin
      response_valid   = 1'b1;
      response_channel = ($urandom_range(0, 1) != 0) ? 5'd7 : 5'($urandom_range(0, 31));
      response_data    = rnd_data();
    end else begin
      response_valid   = 1'b0;
      response_channel = 5'($urandom_range(0, 31));
      response_data    = rnd_data();
    end
  endtask

  task automatic wait_sv(input string nm);
    int n = 0;
    do begin step(); n++; end while (!sample_valid && n < 300);
    chk(nm, 32'(sample_valid), 1);
  endtask

  task automatic wait_hs(input int ch, input string nm);
    int n = 0;
    do begin step(); n++; end
    while (!(command_valid && command_ready && command_channel == 5'(ch)) && n < 300);
    chk(nm, 32'(command_valid && command_ready && command_channel == 5'(ch)), 1);
  endtask

  task automatic wait_cv(input string nm);
    int n = 0;
    do begin step(); n++; end while (!command_valid && n < 300);
    chk(nm, 32'(command_valid), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, 32'(x_data), 2048);
    chk({tag, "_y"}, 32'(y_data), 2048);
    chk({tag, "_dir"}, 32'(direction), 0);
    chk({tag, "_dv"}, 32'(dir_valid), 0);
    chk({tag, "_sv"}, 32'(sample_valid), 0);
    chk({tag, "_to"}, 32'(timeout_err), 0);
    chk({tag, "_tm"}, 32'(tick_missed), 0);
    chk({tag, "_cv"}, 32'(command_valid), 0);
    chk({tag, "_ch"}, 32'(command_channel), 0);
  endtask

  initial begin
    int h;
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_values("rst");
    rst_n = 1'b1;

    // Basic pair: X=100 -> LEFT; fixed latency from X handshake to sample_valid
    rdy_mode = 0; noise_mode = 0; dly_min = 5; dly_max = 5;
    fixed_x = 100; fixed_y = 2048;
    wait_hs(CH_X, "x_handshake");
    h = cyc;
    wait_sv("sv_basic");
    chk("latency", cyc - h, 13);
    chk("basic_x", 32'(x_data), 100);
    chk("basic_y", 32'(y_data), 2048);
    chk("basic_dir", 32'(direction), 2);
    chk("basic_dv", 32'(dir_valid), 1);
    step();
    chk("sv_one_cycle", 32'(sample_valid), 0);

    // Channel-7 responses in flight; Y dominates -> DOWN, then centred pair holds it
    noise_mode = 2; fixed_x = 3500; fixed_y = 300;
    wait_sv("sv_down");
    chk("down_x", 32'(x_data), 3500);
    chk("down_dir", 32'(direction), 1);
    chk("down_dv", 32'(dir_valid), 1);
    fixed_x = 2000; fixed_y = 2100;
    wait_sv("sv_centre");
    chk("centre_dv", 32'(dir_valid), 0);
    chk("centre_dir_held", 32'(direction), 1);
    noise_mode = 0;

    // Command held stable while ready is low for 20 cycles
    rdy_mode = 2; fixed_x = 3000; fixed_y = 1000; dly_min = 3; dly_max = 3;
    wait_cv("stall_start");
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      chk("stall_cv", 32'(command_valid), 1);
      chk("stall_ch", 32'(command_channel), CH_X);
    end
    rdy_mode = 0;
    step();
    chk("ready_cv", 32'(command_valid), 1);
    step();
    chk("advance_cv", 32'(command_valid), 0);
    wait_sv("sv_stall");
    chk("stall_x", 32'(x_data), 3000);
    chk("stall_y", 32'(y_data), 1000);
    chk("stall_dir", 32'(direction), 1);

    // Y response never arrives -> timeout_err 15 cycles after WAIT_Y entry
    drop_y = 1; fixed_x = 500;
    wait_hs(CH_Y, "y_handshake");
    repeat (15) step();
    chk("to_early", 32'(timeout_err), 0);
    step();
    chk("to_pulse", 32'(timeout_err), 1);
    chk("to_x_kept", 32'(x_data), 3000);
    chk("to_y_kept", 32'(y_data), 1000);
    chk("to_idle_cv", 32'(command_valid), 0);
    chk("to_no_sv", 32'(sample_valid), 0);
    step();
    chk("to_one_cycle", 32'(timeout_err), 0);
    drop_y = 0;

    // Randomized traffic with occasional resets
    rdy_mode = 1; noise_mode = 1; dly_min = 0; dly_max = 17;
    fixed_x = -1; fixed_y = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1000 || i == 2000) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
    end

    // Long stall across a tick sets tick_missed; reset mid-WAIT_X clears it
    rdy_mode = 0; noise_mode = 0;
    repeat (60) step();
    rdy_mode = 2;
    wait_cv("tm_start");
    repeat (45) step();
    chk("tm_set", 32'(tick_missed), 1);
    rdy_mode = 0; dly_min = 10; dly_max = 10; fixed_x = 4000; fixed_y = 4000;
    wait_hs(CH_X, "tm_x_handshake");
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("late_resp_x", 32'(x_data), 2048);

    rdy_mode = 1; noise_mode = 1; dly_min = 0; dly_max = 16;
    fixed_x = -1; fixed_y = -1;
    repeat (600) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joystick_adc_sequencer.md
JOYSTICK_ADC_SEQUENCER -- requirements
Module: joystick_adc_sequencer

Interface
REQ-001 Parameter CH_X, default 1: ADC channel number sampled for the X axis.
REQ-002 Parameter CH_Y, default 2: ADC channel number sampled for the Y axis.
REQ-003 Parameter SAMPLE_DIV, default 50000: clock cycles between sample-pair starts; minimum 16.
REQ-004 Parameter TIMEOUT, default 1023: maximum cycles to wait for one response.
REQ-005 Parameters LOW_TH default 1024 and HIGH_TH default 3072: 12-bit direction thresholds.
REQ-006 The block SHALL have the following ports:
- clock_clk  in  1  single system clock; all logic is on its rising edge.
- reset_sink_reset_n  in  1  asynchronous active-low reset.
- command_valid  out  1  command request.
- command_channel  out  5  channel to convert.
- command_startofpacket  out  1  start of packet.
- command_endofpacket  out  1  end of packet.
- command_ready  in  1  ADC accepts the command.
- response_valid  in  1  conversion result present.
- response_channel  in  5  channel of the result.
- response_data  in  12  conversion result.
- response_startofpacket  in  1  ignored.
- response_endofpacket  in  1  ignored.
- x_data  out  12  last accepted X sample.
- y_data  out  12  last accepted Y sample.
- sample_valid  out  1  one-cycle pulse when x_data and y_data update together.
- direction  out  2  decoded direction (UP/DOWN/LEFT/RIGHT).
- dir_valid  out  1  direction holds a deflection from the latest pair.
- timeout_err  out  1  one-cycle pulse on response timeout.
- tick_missed  out  1  sticky flag: a sample tick arrived while busy.

Function
REQ-007 A free-running period counter SHALL count 0..SAMPLE_DIV-1, wrap to 0, and raise an internal tick on the wrap cycle.
REQ-008 The FSM SHALL have the states IDLE, CMD_X, WAIT_X, CMD_Y, WAIT_Y and UPDATE.
REQ-009 IDLE SHALL go to CMD_X on a tick; a tick in any other state SHALL set tick_missed and is not queued.
REQ-010 In CMD_X and CMD_Y the block SHALL assert command_valid=1 and command_startofpacket=command_endofpacket=1, with command_channel=CH_X or CH_Y respectively.
REQ-011 Command outputs SHALL remain stable until the cycle in which command_valid and command_ready are both 1; the FSM then advances to WAIT_X or WAIT_Y.
REQ-012 command_valid SHALL be 0 in all states other than CMD_X and CMD_Y.
REQ-013 In WAIT_X and WAIT_Y the FSM SHALL capture response_data on the first cycle with response_valid=1 and response_channel equal to the expected channel.
REQ-014 A valid response with a non-matching channel SHALL be discarded and SHALL NOT restart the timeout.
REQ-015 The FSM SHALL go WAIT_X -> CMD_Y and WAIT_Y -> UPDATE.
REQ-016 The timeout counter SHALL clear on entry to each WAIT state.
REQ-017 When the timeout counter reaches TIMEOUT without a matching response, the block SHALL pulse timeout_err for one cycle and return to IDLE without updating any outputs.
REQ-018 In UPDATE (one cycle), the block SHALL transfer the captured X and Y values to x_data and y_data, pulse sample_valid, update direction and dir_valid, and return to IDLE.
REQ-019 Direction decode SHALL use the signed 13-bit deviations dx=x-2048 and dy=y-2048.
REQ-020 An axis SHALL be deflected when its value is below LOW_TH or above HIGH_TH.
REQ-021 If neither axis is deflected, dir_valid SHALL be 0 and direction SHALL hold its previous value.
REQ-022 Otherwise the axis with the larger |deviation| SHALL win, with X winning ties: x<LOW_TH gives LEFT, x>HIGH_TH gives RIGHT, y>HIGH_TH gives UP, y<LOW_TH gives DOWN.
REQ-023 Sample-to-sample_valid latency SHALL be command handshake + response + 1 cycle per axis, plus 1 cycle for UPDATE.
REQ-024 A response arriving in the same cycle as the X command handshake SHALL be ignored (the FSM is not yet in WAIT_X).

Reset
REQ-025 On reset_sink_reset_n=0 the FSM SHALL go to IDLE and all counters SHALL clear, asynchronously.
REQ-026 During reset, x_data and y_data SHALL be 2048, direction SHALL be UP, and all 1-bit outputs and command_channel SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction; a late response after reset SHALL be ignored in IDLE.

Structure
REQ-028 Package joystick_pkg SHALL hold the direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3), the FSM state type, and the constant ADC_MID=2048.
REQ-029 The direction decode SHALL be the combinational sub-module joystick_dir_decode, instantiated once.

Verification
REQ-030 SAMPLE_DIV=100, ready tied 1, responses X=100 and Y=2048 after 5 cycles -> sample_valid pulse, x_data=100, direction=LEFT, dir_valid=1.
REQ-031 command_ready held 0 for 20 cycles in CMD_X -> command_valid and command_channel=CH_X stable throughout; advance on the first ready cycle.
REQ-032 No response in WAIT_Y with TIMEOUT=15 -> timeout_err pulses 15 cycles after entry, x_data and y_data unchanged, FSM back in IDLE.
REQ-033 Response on channel 7 then channel CH_X in WAIT_X -> only the CH_X data is captured.
REQ-034 X=3500 and Y=300 (|dx|=1452 < |dy|=1748) -> direction=DOWN; X=2000 and Y=2100 -> dir_valid=0 with direction held.
REQ-035 SAMPLE_DIV=16 with responses delayed 30 cycles -> tick_missed=1; reset asserted mid-WAIT_X -> x_data=2048 and tick_missed=0.
